// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle RV32M divide/remainder unit.
// Latches operands on start, resolves divide-by-zero and signed overflow in one
// cycle, otherwise runs a 32-step restoring division (one quotient bit per cycle).
//
// Handshake: start is accepted only while busy=0 and the requester holds the
// instruction until done; done is a one-cycle pulse with res valid in that
// cycle, and res holds its value until the next done (or reset). A flush forces
// IDLE without producing done or touching res.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      div_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          r_state;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_res;

  // Operand decode for the accept cycle
  logic            w_signed;
  logic            w_div_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;

  assign w_signed   = ~div_op[0];
  assign w_div_zero = (op_b == '0);
  assign w_ovf      = w_signed && (op_a == MIN_NEG) && (op_b == '1);
  assign w_abs_a    = (w_signed && op_a[XLEN-1]) ? -op_a : op_a;
  assign w_abs_b    = (w_signed && op_b[XLEN-1]) ? -op_b : op_b;

  // One restoring-division step. The shifted remainder is XLEN+1 bits wide;
  // after a subtract the true result is below the divisor, so the low XLEN
  // bits of a modular subtract are exact.
  logic [XLEN:0]   w_shift;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_dvd_next;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;

  assign w_shift    = {r_rem, r_dvd[XLEN-1]};
  assign w_ge       = (w_shift >= {1'b0, r_divisor});
  assign w_rem_next = w_ge ? (w_shift[XLEN-1:0] - r_divisor) : w_shift[XLEN-1:0];
  assign w_dvd_next = {r_dvd[XLEN-2:0], w_ge};
  assign w_q_fix    = r_neg_q ? -w_dvd_next : w_dvd_next;
  assign w_r_fix    = r_neg_r ? -w_rem_next : w_rem_next;

  // Control FSM and datapath registers; flush overrides everything but reset
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_is_rem  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_cnt     <= '0;
      r_divisor <= '0;
      r_dvd     <= '0;
      r_rem     <= '0;
      r_res     <= '0;
    end else if (flush) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_is_rem <= div_op[1];
            if (w_div_zero) begin
              r_res   <= div_op[1] ? op_a : '1;
              r_state <= DONE;
            end else if (w_ovf) begin
              r_res   <= div_op[1] ? '0 : MIN_NEG;
              r_state <= DONE;
            end else begin
              r_dvd     <= w_abs_a;
              r_divisor <= w_abs_b;
              r_rem     <= '0;
              r_cnt     <= '0;
              r_neg_q   <= w_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
              r_neg_r   <= w_signed & op_a[XLEN-1];
              r_state   <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_dvd <= w_dvd_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_res   <= r_is_rem ? w_r_fix : w_q_fix;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign res       = r_res;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed and randomized checks of div_sequencer against an
// arithmetic reference model of the RV32M divide/remainder rules.
module tb_div_sequencer;

  logic        CLK;
  logic        rst;
  logic        start;
  logic [1:0]  div_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = 32'h0;

  div_sequencer #(.XLEN(32)) dut (
    .CLK       (CLK),
    .rst       (rst),
    .start     (start),
    .div_op    (div_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .res       (res),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: RISC-V M-extension results from plain arithmetic
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    model = (b == 0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
      2'd1:    model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2:    model = (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sb));
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver: issue one operation, optionally pulse a stray start while busy,
  // and score latency, busy, result and post-done state.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    int lat;
    int exp_lat;
    bit seen;
    bit busy_ok;
    logic [31:0] exp;
    exp_q.push_back(model(op, a, b));
    exp_lat = model_latency(op, a, b);
    @(negedge CLK);
    start = 1'b1; div_op = op; op_a = a; op_b = b;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 1; seen = 0; busy_ok = 1;
    while (!seen && lat <= 40) begin
      if (busy !== 1'b1) busy_ok = 0;
      if (done === 1'b1) seen = 1;
      else begin
        if (inject && lat == 5) begin
          start = 1'b1; div_op = 2'($urandom); op_a = $urandom; op_b = $urandom | 32'h1;
        end
        @(posedge CLK); #1;
        start = 1'b0;
        lat++;
      end
    end
    exp = exp_q.pop_front();
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_res"}, res, exp);
      check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
      last_res = exp;
    end
    @(posedge CLK); #1;
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'd0);
    check({tag, "_res_held"}, res, last_res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; div_op = 2'd0; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res", res, 32'h0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge CLK);
    rst = 1'b0;

    // Directed cases
    run_op("div_neg",  2'd0, 32'hFFFF_FFEC, 32'd6, 0);
    check("div_neg_const", res, 32'hFFFF_FFFD);
    run_op("rem_neg",  2'd2, 32'hFFFF_FFEC, 32'd6, 0);
    check("rem_neg_const", res, 32'hFFFF_FFFE);
    run_op("divu",     2'd1, 32'hFFFF_FFEC, 32'd6, 0);
    check("divu_const", res, 32'h2AAA_AAA7);
    run_op("remu",     2'd3, 32'hFFFF_FFEC, 32'd6, 0);
    check("remu_const", res, 32'h0000_0002);
    for (int op = 0; op < 4; op++) begin
      run_op("dz", 2'(op), 32'h0000_1234, 32'h0, 0);
      check("dz_const", res, op[1] ? 32'h0000_1234 : 32'hFFFF_FFFF);
    end
    run_op("ovf_div",  2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("ovf_div_const", res, 32'h8000_0000);
    run_op("ovf_rem",  2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("ovf_rem_const", res, 32'h0);
    run_op("ovf_divu", 2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("ovf_divu_const", res, 32'h0);

    // Flush mid-calculation: no done, res unchanged
    @(negedge CLK);
    start = 1'b1; div_op = 2'd1; op_a = 32'd100; op_b = 32'd7;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (9) @(posedge CLK);
    @(negedge CLK);
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_done", 32'(done), 32'd0);
    check("flush_res", res, last_res);
    repeat (2) begin
      @(posedge CLK); #1;
      check("flush_no_done", 32'(done), 32'd0);
    end
    run_op("after_flush", 2'd1, 32'd100, 32'd7, 0);
    check("after_flush_const", res, 32'h0000_000E);

    // Stray start while busy is ignored
    run_op("inject", 2'd0, 32'd1000, 32'hFFFF_FFF9, 1);

    // Randomized operations with occasional corner operands
    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: ra = $urandom_range(0, 100);
        default: ;
      endcase
      run_op("rand", 2'($urandom_range(0, 3)), ra, rb, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset mid-CALC
    run_op("pre_rst", 2'd1, 32'd12345, 32'd3, 0);
    @(negedge CLK);
    start = 1'b1; div_op = 2'd1; op_a = 32'd5000; op_b = 32'd9;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_res", res, 32'h0);
    check("arst_state", 32'(dbg_state), 32'd0);
    @(negedge CLK);
    rst = 1'b0;
    last_res = 32'h0;
    run_op("post_rst", 2'd3, 32'd5000, 32'd9, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
